// File: rtl/regfile_loader.sv
// Byte-stream loader that rewrites a block of core registers via the a3/wd3/we3 port.
// Optional trailing checksum byte: define REGFILE_LOADER_CHECKSUM_EN.
module regfile_loader #(
    parameter int START_REG = 0,
    parameter int NUM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [4:0]  a3,
    output logic [31:0] wd3,
    output logic        we3,
    output logic        core_stall,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHK   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [5:0] LAST = 6'(NUM_WORDS - 1);
    localparam logic [4:0] BASE = 5'(START_REG);

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_idx;
    logic [1:0]  r_bcnt;
    logic [23:0] r_word;
    logic        w_hs;
    logic        w_start_acc;
    logic        w_last;
    logic        w_ready_d;
    logic        w_busy_d;
    logic        w_we_d;
    logic        w_done_d;

    // abort wins over a simultaneous byte handshake
    assign w_hs        = s_valid & s_ready & ~abort;
    assign w_start_acc = (r_state == IDLE) & start;
    assign w_last      = (r_idx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = RECV;
            end
            RECV: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_hs && r_bcnt == 2'd3) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_last) begin
`ifdef REGFILE_LOADER_CHECKSUM_EN
                    w_next = CHK;
`else
                    w_next = DONE;
`endif
                end else begin
                    w_next = RECV;
                end
            end
            CHK: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_hs) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        w_ready_d = (w_next == RECV) || (w_next == CHK);
        w_busy_d  = (w_next != IDLE);
        w_we_d    = (w_next == WRITE);
        w_done_d  = (w_next == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready    <= 1'b0;
            we3        <= 1'b0;
            busy       <= 1'b0;
            core_stall <= 1'b0;
            done       <= 1'b0;
        end else begin
            s_ready    <= w_ready_d;
            we3        <= w_we_d;
            busy       <= w_busy_d;
            core_stall <= w_busy_d;
            done       <= w_done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_bcnt <= '0;
            r_word <= '0;
            a3     <= '0;
            wd3    <= '0;
        end else if (w_start_acc) begin
            r_idx  <= '0;
            r_bcnt <= '0;
        end else if (r_state == RECV && w_hs) begin
            r_word <= {s_data, r_word[23:8]};
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
                wd3 <= {s_data, r_word};
                a3  <= BASE + r_idx[4:0];
            end
        end else if (r_state == WRITE && !abort) begin
            r_idx <= r_idx + 6'd1;
        end
    end

`ifdef REGFILE_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum  <= '0;
            r_error <= 1'b0;
        end else if (w_start_acc) begin
            r_csum  <= '0;
            r_error <= 1'b0;
        end else if (r_state == RECV && w_hs) begin
            r_csum <= r_csum + s_data;
        end else if (r_state == CHK && w_hs) begin
            r_error <= (s_data != r_csum);
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule
